// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode-class one-hot encoding and register
// address width, used by every pipeline stage.
package rv32i_pkg;

   // One-hot opcode classes carried down the pipeline
   localparam int OPCODE_WIDTH   = 11;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int XLEN           = 32;

   // Bit positions inside the one-hot opcode-class vector
   localparam int LUI    = 0;
   localparam int AUIPC  = 1;
   localparam int JAL    = 2;
   localparam int JALR   = 3;
   localparam int BRANCH = 4;
   localparam int LOAD   = 5;
   localparam int STORE  = 6;
   localparam int ITYPE  = 7;
   localparam int RTYPE  = 8;
   localparam int FENCE  = 9;
   localparam int SYSTEM = 10;

   // Register x0 is hardwired to zero and never written
   localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: increments by one per retire request and
// wraps naturally from all-ones back to zero.
module retire_counter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Synchronous active-low clear, then count each increment request
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (inc) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/writeback.sv
// Writeback stage of the RV32I pipeline.
// Registers the memory-stage result into the register-file write port
// (also the forwarding source) with one cycle of latency, and pulses
// writeback_retire once per retired instruction.
// Optional feature: define WRITEBACK_INSTRET_EN to add the instret
// retired-instruction counter (retire_counter sub-module) and port.
//
// Stage handshake: an instruction moves from the memory stage into this
// stage when accept = clk_en && !stall && !flush. Flush beats stall and
// stall beats accept. On a stall the outputs freeze; on flush or a low
// clk_en the write enable and retire pulse drop while data/rd/pc hold.
module writeback
   import rv32i_pkg::*;
#(
   parameter int INSTRET_WIDTH = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [OPCODE_WIDTH-1:0]   memory_opcode_type,
   input  logic [XLEN-1:0]           memory_pc,
   input  logic                      memory_rd_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] memory_rd,
   input  logic [XLEN-1:0]           memory_rd_wr_data,
   input  logic [XLEN-1:0]           memory_data_load,
   input  logic                      clk_en,
   input  logic                      stall,
   input  logic                      flush,
   output logic                      writeback_rd_wr_en,
   output logic [REG_ADDR_WIDTH-1:0] writeback_rd,
   output logic [XLEN-1:0]           writeback_rd_wr_data,
   output logic [XLEN-1:0]           writeback_pc,
   output logic                      writeback_retire,
`ifdef WRITEBACK_INSTRET_EN
   output logic [INSTRET_WIDTH-1:0]  instret,
`endif
   output logic                      next_stall,
   output logic                      next_flush
);

   logic            accept;
   logic            is_load;
   logic [XLEN-1:0] wr_data_sel;
   logic            wr_en_sel;

   // Only the LOAD class bit matters here; the rest of the one-hot
   // vector is consumed by earlier stages.
   logic            opcode_unused;
   assign opcode_unused = &memory_opcode_type;

   assign accept = clk_en && !stall && !flush;
   assign is_load = memory_opcode_type[LOAD];

   // Select load data for loads, execute result otherwise; suppress x0 writes
   always_comb begin
      wr_data_sel = memory_rd_wr_data;
      if (is_load) begin
         wr_data_sel = memory_data_load;
      end
      wr_en_sel = memory_rd_wr_en && (memory_rd != REG_ZERO);
   end

   // Stall/flush requests travel back to the memory stage; flush wins
   assign next_stall = stall && !flush;
   assign next_flush = flush;

   // Pipeline register: reset > (flush or disabled) > stall > accept
   always_ff @(posedge clk) begin
      if (!rst) begin
         writeback_rd_wr_en   <= 1'b0;
         writeback_rd         <= '0;
         writeback_rd_wr_data <= '0;
         writeback_pc         <= '0;
         writeback_retire     <= 1'b0;
      end else if (!clk_en || flush) begin
         writeback_rd_wr_en <= 1'b0;
         writeback_retire   <= 1'b0;
      end else if (stall) begin
         writeback_retire <= 1'b0;
      end else begin
         writeback_rd_wr_en   <= wr_en_sel;
         writeback_rd         <= memory_rd;
         writeback_rd_wr_data <= wr_data_sel;
         writeback_pc         <= memory_pc;
         writeback_retire     <= 1'b1;
      end
   end

`ifdef WRITEBACK_INSTRET_EN
   // Count every accepted instruction
   retire_counter #(
      .WIDTH (INSTRET_WIDTH)
   ) u_retire_counter (
      .clk   (clk),
      .rst   (rst),
      .inc   (accept),
      .count (instret)
   );
`else
   // No counter in this build; keep the width parameter referenced
   logic [INSTRET_WIDTH-1:0] instret_unused;
   logic                     accept_unused;
   assign instret_unused = '0;
   assign accept_unused  = accept;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: reset, a table of single-cycle
// vectors with hand-computed results, then stall/flush, reset-override and
// (with WRITEBACK_INSTRET_EN) counter-wrap sequences.
module tb_writeback;
   import rv32i_pkg::*;

   logic        clk;
   logic        rst;
   logic [OPCODE_WIDTH-1:0] memory_opcode_type;
   logic [31:0] memory_pc;
   logic        memory_rd_wr_en;
   logic [4:0]  memory_rd;
   logic [31:0] memory_rd_wr_data;
   logic [31:0] memory_data_load;
   logic        clk_en;
   logic        stall;
   logic        flush;
   logic        writeback_rd_wr_en;
   logic [4:0]  writeback_rd;
   logic [31:0] writeback_rd_wr_data;
   logic [31:0] writeback_pc;
   logic        writeback_retire;
   logic        next_stall;
   logic        next_flush;

   int n_cmp;
   int n_err;
   logic [63:0] exp_instret;

`ifdef WRITEBACK_INSTRET_EN
   logic [3:0] instret;
   writeback #(.INSTRET_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .memory_opcode_type(memory_opcode_type), .memory_pc(memory_pc),
      .memory_rd_wr_en(memory_rd_wr_en), .memory_rd(memory_rd),
      .memory_rd_wr_data(memory_rd_wr_data), .memory_data_load(memory_data_load),
      .clk_en(clk_en), .stall(stall), .flush(flush),
      .writeback_rd_wr_en(writeback_rd_wr_en), .writeback_rd(writeback_rd),
      .writeback_rd_wr_data(writeback_rd_wr_data), .writeback_pc(writeback_pc),
      .writeback_retire(writeback_retire), .instret(instret),
      .next_stall(next_stall), .next_flush(next_flush)
   );
`else
   writeback dut (
      .clk(clk), .rst(rst),
      .memory_opcode_type(memory_opcode_type), .memory_pc(memory_pc),
      .memory_rd_wr_en(memory_rd_wr_en), .memory_rd(memory_rd),
      .memory_rd_wr_data(memory_rd_wr_data), .memory_data_load(memory_data_load),
      .clk_en(clk_en), .stall(stall), .flush(flush),
      .writeback_rd_wr_en(writeback_rd_wr_en), .writeback_rd(writeback_rd),
      .writeback_rd_wr_data(writeback_rd_wr_data), .writeback_pc(writeback_pc),
      .writeback_retire(writeback_retire),
      .next_stall(next_stall), .next_flush(next_flush)
   );
`endif

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        clk_en;
      logic        stall;
      logic        flush;
      logic        is_load;
      logic        rd_wr_en;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] rd_wr_data;
      logic [31:0] data_load;
      logic        exp_wr_en;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      logic [31:0] exp_pc;
      logic        exp_retire;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ce, input logic st, input logic fl, input logic ld,
                        input logic we, input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] wd, input logic [31:0] dl);
      clk_en = ce;
      stall = st;
      flush = fl;
      memory_opcode_type = '0;
      if (ld) memory_opcode_type[LOAD] = 1'b1;
      else    memory_opcode_type[RTYPE] = 1'b1;
      memory_rd_wr_en = we;
      memory_rd = rd;
      memory_pc = pc;
      memory_rd_wr_data = wd;
      memory_data_load = dl;
   endtask

   // One clock edge; the instret model follows the driven inputs
   task automatic tick();
      @(posedge clk);
      if (!rst) exp_instret = '0;
      else if (clk_en && !stall && !flush) exp_instret = exp_instret + 64'd1;
      #1;
   endtask

   task automatic check_outs(input string tag, input logic we, input logic [4:0] rd,
                             input logic [31:0] d, input logic [31:0] pc, input logic ret);
      check({tag, ".wr_en"},  {63'd0, writeback_rd_wr_en}, {63'd0, we});
      check({tag, ".rd"},     {59'd0, writeback_rd}, {59'd0, rd});
      check({tag, ".data"},   {32'd0, writeback_rd_wr_data}, {32'd0, d});
      check({tag, ".pc"},     {32'd0, writeback_pc}, {32'd0, pc});
      check({tag, ".retire"}, {63'd0, writeback_retire}, {63'd0, ret});
`ifdef WRITEBACK_INSTRET_EN
      check({tag, ".instret"}, {60'd0, instret}, exp_instret & 64'hF);
`endif
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      exp_instret = '0;

      //                ce  st  fl  ld  we  rd     pc            wr_data       load          e_we e_rd   e_data        e_pc          e_ret
      vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,5'd5, 32'h0000_0100,32'h1234_5678,32'h0000_0000,1'b1,5'd5, 32'h1234_5678,32'h0000_0100,1'b1};
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,5'd7, 32'h0000_0104,32'h0000_0100,32'hFFFF_FF80,1'b1,5'd7, 32'hFFFF_FF80,32'h0000_0104,1'b1};
      vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,5'd0, 32'h0000_0108,32'h0000_AAAA,32'h0000_0000,1'b0,5'd0, 32'h0000_AAAA,32'h0000_0108,1'b1};
      vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,5'd9, 32'h0000_010C,32'h0000_0055,32'h0000_0011,1'b0,5'd9, 32'h0000_0055,32'h0000_010C,1'b1};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,5'd31,32'h0000_0110,32'hDEAD_BEEF,32'h0000_0022,1'b1,5'd31,32'hDEAD_BEEF,32'h0000_0110,1'b1};
      vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,5'd3, 32'h0000_0200,32'h0000_0001,32'h0000_0002,1'b0,5'd31,32'hDEAD_BEEF,32'h0000_0110,1'b0};
      vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b1,5'd12,32'h0000_0114,32'hCAFE_F00D,32'h0000_0077,1'b1,5'd12,32'hCAFE_F00D,32'h0000_0114,1'b1};
      vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,5'd1, 32'h0000_0300,32'h0000_0002,32'h0000_0003,1'b1,5'd12,32'hCAFE_F00D,32'h0000_0114,1'b0};
      vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b1,5'd1, 32'h0000_0300,32'h0000_0002,32'h0000_0003,1'b0,5'd12,32'hCAFE_F00D,32'h0000_0114,1'b0};
      vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,1'b1,5'd4, 32'h0000_0304,32'h0000_0005,32'h0000_0006,1'b0,5'd12,32'hCAFE_F00D,32'h0000_0114,1'b0};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b1,1'b1,5'd2, 32'h0000_0118,32'h0000_0123,32'h0000_0080,1'b1,5'd2, 32'h0000_0080,32'h0000_0118,1'b1};

      // Reset held while an accept is presented: nothing may be captured
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0500, 32'h0000_0099, 32'h0);
      tick();
      tick();
      check_outs("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;

      // Table-driven single-cycle vectors
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].clk_en, vecs[i].stall, vecs[i].flush, vecs[i].is_load,
               vecs[i].rd_wr_en, vecs[i].rd, vecs[i].pc, vecs[i].rd_wr_data, vecs[i].data_load);
         #1;
         check($sformatf("v%0d.next_stall", i), {63'd0, next_stall},
               {63'd0, vecs[i].stall && !vecs[i].flush});
         check($sformatf("v%0d.next_flush", i), {63'd0, next_flush}, {63'd0, vecs[i].flush});
         tick();
         check_outs($sformatf("v%0d", i), vecs[i].exp_wr_en, vecs[i].exp_rd,
                    vecs[i].exp_data, vecs[i].exp_pc, vecs[i].exp_retire);
      end

      // Stall three cycles then flush one cycle
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h0000_0400, 32'h0000_0600, 32'h0);
      tick();
      check_outs("pre_stall", 1'b1, 5'd6, 32'h0000_0600, 32'h0000_0400, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'(10 + k), 32'h0000_0410 + 32'(k),
               32'h0000_0700 + 32'(k), 32'h0000_0800 + 32'(k));
         #1;
         check($sformatf("stall%0d.next_stall", k), {63'd0, next_stall}, 64'd1);
         tick();
         check_outs($sformatf("stall%0d", k), 1'b1, 5'd6, 32'h0000_0600, 32'h0000_0400, 1'b0);
      end
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_0420, 32'h0000_0900, 32'h0);
      #1;
      check("flush.next_stall", {63'd0, next_stall}, 64'd0);
      check("flush.next_flush", {63'd0, next_flush}, 64'd1);
      tick();
      check_outs("flush", 1'b0, 5'd6, 32'h0000_0600, 32'h0000_0400, 1'b0);

      // Reset during an accept discards the in-flight write
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0000_0600, 32'h0000_0888, 32'h0);
      tick();
      check_outs("pre_rst", 1'b1, 5'd8, 32'h0000_0888, 32'h0000_0600, 1'b1);
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0604, 32'h0000_0999, 32'h0);
      tick();
      check_outs("rst_accept", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0604, 32'h0000_0999, 32'h0);
      tick();
      check_outs("post_rst", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);

`ifdef WRITEBACK_INSTRET_EN
      // 17 accepts on a 4-bit counter wrap to 1
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int k = 0; k < 17; k++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'(k * 4), 32'(k), 32'h0);
         tick();
      end
      check("wrap.instret", {60'd0, instret}, 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
- REQ-001 SHALL have parameter INSTRET_WIDTH, default 64, giving the retired-instruction counter width.
- REQ-002 SHALL have port clk, input, 1: the single clock; all state is updated on its rising edge.
- REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
- REQ-004 SHALL have port memory_opcode_type, input, `OPCODE_WIDTH: one-hot opcode class from the memory stage.
- REQ-005 SHALL have port memory_pc, input, 32: PC of the instruction in the memory stage.
- REQ-006 SHALL have port memory_rd_wr_en, input, 1: rd write request from the memory stage.
- REQ-007 SHALL have port memory_rd, input, 5: destination register address.
- REQ-008 SHALL have port memory_rd_wr_data, input, 32: execute result, used for non-load instructions.
- REQ-009 SHALL have port memory_data_load, input, 32: extended load data, used for loads.
- REQ-010 SHALL have port clk_en, input, 1: stage enable, driven by the memory stage next_clk_en.
- REQ-011 SHALL have ports stall and flush, input, 1 each: stage stall and flush requests.
- REQ-012 SHALL have ports writeback_rd_wr_en (1), writeback_rd (5) and writeback_rd_wr_data (32), output: the base-register write port, also used as the forwarding source.
- REQ-013 SHALL have port writeback_pc, output, 32: PC of the instruction being written back.
- REQ-014 SHALL have port writeback_retire, output, 1: one-cycle pulse for each retired instruction.
- REQ-015 SHALL have port instret, output, INSTRET_WIDTH: count of retired instructions (present only under REQ-029).
- REQ-016 SHALL have ports next_stall and next_flush, output, 1 each: propagated to the memory stage.

Function
- REQ-017 SHALL define accept = clk_en && !stall && !flush.
- REQ-018 On accept, SHALL register the write data: memory_data_load when memory_opcode_type[`LOAD] is set, otherwise memory_rd_wr_data.
- REQ-019 On accept, SHALL register writeback_rd and writeback_pc.
- REQ-020 On accept, SHALL register writeback_rd_wr_en = memory_rd_wr_en && (memory_rd != 0); a write to x0 is never issued.
- REQ-021 Latency SHALL be exactly one cycle from the memory-stage inputs to the writeback outputs.
- REQ-022 On a cycle where clk_en is high and stall is high, SHALL hold all registered outputs and deassert writeback_retire.
- REQ-023 On a cycle where clk_en is low, or flush is high, SHALL clear writeback_rd_wr_en and writeback_retire; data, rd and pc outputs hold.
- REQ-024 Flush SHALL take priority over stall, and stall over accept.
- REQ-025 writeback_retire SHALL be high in the cycle after each accept, and only then.
- REQ-026 next_stall SHALL be combinational stall && !flush; next_flush SHALL be combinational flush.

Reset
- REQ-027 While rst is low at a clock edge, SHALL clear writeback_rd_wr_en, writeback_rd, writeback_rd_wr_data, writeback_pc, writeback_retire and instret to zero.
- REQ-028 Reset SHALL override a stall, flush or accept in the same cycle; an in-flight write SHALL be discarded and never issued.

Configuration
- REQ-029 With macro WRITEBACK_INSTRET_EN defined, SHALL implement instret, incremented by 1 on each accept, wrapping from all-ones to zero.
- REQ-030 Without WRITEBACK_INSTRET_EN, the instret port and counter SHALL be absent; writeback_retire remains present.

Structure
- REQ-031 `OPCODE_WIDTH, the opcode-class bit indices (`LOAD etc.) and the register-address width SHALL come from the shared rv32i header/package; no local redefinition.
- REQ-032 The instret counter SHALL be a sub-module, retire_counter (parameter WIDTH; ports clk, rst, inc, count), instantiated only under WRITEBACK_INSTRET_EN.

Verification
- REQ-033 ALU op: rd=5, memory_rd_wr_data=0x1234_5678, clk_en=1 -> next cycle wb_rd_wr_en=1, rd=5, data=0x1234_5678, retire=1.
- REQ-034 Load: `LOAD set, memory_data_load=0xFFFF_FF80, memory_rd_wr_data=0x100 -> data=0xFFFF_FF80.
- REQ-035 x0 write: rd=0, memory_rd_wr_en=1 -> writeback_rd_wr_en=0 and retire=1.
- REQ-036 Stall for 3 cycles, then flush held 1 cycle -> outputs frozen for 3 cycles, next_stall=1 during them, then wr_en=0 and retire=0, next_stall=0 while flush is high.
- REQ-037 Counter wrap (WRITEBACK_INSTRET_EN, INSTRET_WIDTH=4): 17 accepts -> instret=1.
- REQ-038 rst low during an accept cycle -> all outputs 0 next cycle; the write is not issued.
